// File: rtl/pc_sweep_sequencer.sv
// Sweeps the processor PC over an address range, waits a settle interval per address,
// and captures each Out value into a FIFO that a controller drains through a pop handshake.
module pc_sweep_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_Addr,
    input  logic [ADDR_W-1:0] End_Addr,
    input  logic              Load,
    input  logic [ADDR_W-1:0] Load_Addr,
    input  logic [DATA_W-1:0] Proc_Out,
    output logic [ADDR_W-1:0] PC_N,
    output logic              Enable,
    output logic              Busy,
    output logic              Done,
    input  logic              Rd_En,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Rd_Valid,
    output logic              Empty,
    output logic              Full
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, end_q, load_addr_q, next_pc;
    logic              load_pend_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    logic accept_start, issue, push, pop, last_addr;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;

    assign pop       = Rd_En && !Empty;
    assign last_addr = (pc_q == end_q);
    assign next_pc   = load_pend_q ? load_addr_q : pc_q + ADDR_W'(1);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        issue        = 1'b0;
        push         = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    accept_start = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A pop in the same cycle frees the slot, so a full FIFO need not stall.
                if (!Full || pop) begin
                    push    = 1'b1;
                    state_d = last_addr ? S_DONE : S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            end_q       <= '0;
            load_pend_q <= 1'b0;
            load_addr_q <= '0;
            wait_cnt_q  <= '0;
            PC_N        <= '0;
            Enable      <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                pc_q  <= Start_Addr;
                end_q <= End_Addr;
                Busy  <= 1'b1;
                Done  <= 1'b0;
            end
            if (issue) begin
                PC_N       <= pc_q;
                Enable     <= 1'b1;
                wait_cnt_q <= CNT_W'(SETTLE - 1);
            end
            if (state_q == S_WAIT && wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - CNT_W'(1);
            end
            if (push && last_addr) begin
                // Final capture: any Load arriving now has nowhere to go and is dropped.
                Enable      <= 1'b0;
                Busy        <= 1'b0;
                Done        <= 1'b1;
                load_pend_q <= 1'b0;
            end else begin
                if (push) begin
                    pc_q        <= next_pc;
                    load_pend_q <= 1'b0;
                end
                // A fresh Load wins over the consume-and-clear above and becomes the next redirect.
                if (Load && Busy) begin
                    load_pend_q <= 1'b1;
                    load_addr_q <= Load_Addr;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr_q] <= Proc_Out;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            Empty    <= 1'b1;
            Full     <= 1'b0;
            Rd_Data  <= '0;
            Rd_Valid <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                Rd_Data  <= mem[rd_ptr_q];
            end
            Rd_Valid <= pop;
            count_q  <= count_d;
            Empty    <= (count_d == '0);
            Full     <= (count_d == FULL_CNT);
        end
    end

endmodule

// File: tb/tb_pc_sweep_sequencer.sv
// Directed bench for pc_sweep_sequencer: a per-cycle vector table for the basic sweep,
// then hand-written sequences for stall, redirect, wrap-around and mid-sweep reset.
module tb_pc_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [7:0]  end_addr = '0;
    logic        load = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [15:0] proc_out;
    logic [7:0]  pc_n;
    logic        enable, busy, done;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid, empty, full;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Processor stand-in: Out = PC_N * 16'h0101.
    assign proc_out = 16'(pc_n) * 16'h0101;

    pc_sweep_sequencer dut (
        .Clock     (clk),
        .Reset_n   (rst_n),
        .Start     (start),
        .Start_Addr(start_addr),
        .End_Addr  (end_addr),
        .Load      (load),
        .Load_Addr (load_addr),
        .Proc_Out  (proc_out),
        .PC_N      (pc_n),
        .Enable    (enable),
        .Busy      (busy),
        .Done      (done),
        .Rd_En     (rd_en),
        .Rd_Data   (rd_data),
        .Rd_Valid  (rd_valid),
        .Empty     (empty),
        .Full      (full)
    );

    typedef struct {
        logic        start;
        logic [7:0]  sa;
        logic [7:0]  ea;
        logic        rd_en;
        logic [7:0]  pc;
        logic        en, bsy, dn, emp, ful, rv;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [7:0] sa, input logic [7:0] ea,
                                input logic rd, input logic [7:0] pc, input logic en,
                                input logic bsy, input logic dn, input logic emp,
                                input logic ful, input logic rv, input logic [15:0] rdd);
        vec_t v;
        v.start = st; v.sa = sa; v.ea = ea; v.rd_en = rd;
        v.pc = pc; v.en = en; v.bsy = bsy; v.dn = dn; v.emp = emp; v.ful = ful;
        v.rv = rv; v.rd = rdd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({pc_n, enable, busy, done, empty, full, rd_valid, rd_data});
    endfunction

    // Runs one sweep, optionally driving Load or a stray Start during the WAIT of the
    // first address, and compares the sequence of issued PCs with the expected one.
    task automatic sweep(input string name, input logic [7:0] sa, input logic [7:0] ea,
                         input bit mid_start, input bit mid_load, input logic [7:0] mid_addr,
                         input int exp_n, input logic [31:0] exp_seq);
        int          cyc;
        int          got_n;
        logic [31:0] got_seq;
        start = 1'b1; start_addr = sa; end_addr = ea;
        step();
        start = 1'b0;
        cyc = 0; got_n = 0; got_seq = '0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
            if (enable && (got_n == 0 || pc_n != got_seq[7:0])) begin
                got_seq = {got_seq[23:0], pc_n};
                got_n++;
            end
            if (cyc == 1) begin
                start = mid_start; start_addr = mid_addr; end_addr = mid_addr;
                load = mid_load; load_addr = mid_addr;
            end else begin
                start = 1'b0;
                load  = 1'b0;
            end
        end
        start = 1'b0;
        load  = 1'b0;
        check({name, "_done"}, 64'({done, busy, enable}), 64'(3'b100));
        check({name, "_seq"}, 64'({got_n[7:0], got_seq}), 64'({exp_n[7:0], exp_seq}));
    endtask

    // Pops n values (first in the top 16 bits of vals), then pops once more on empty.
    task automatic drain(input string name, input int n, input logic [63:0] vals);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            step();
            check({name, "_pop"}, 64'({rd_valid, rd_data}), 64'({1'b1, vals[63-16*i -: 16]}));
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check({name, "_pop_empty"}, 64'({rd_valid, empty, full}), 64'(3'b010));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int k;

        // Basic sweep 0..3, one row per clock: inputs before the edge, outputs after it.
        vecs.push_back(mk(1, 8'h00, 8'h03, 0, 8'h00, 0, 1, 0, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h00, 1, 1, 0, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h00, 1, 1, 0, 1, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h00, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h01, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h01, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h01, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h02, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h02, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h02, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h03, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h03, 1, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h03, 0, 0, 1, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 1, 8'h03, 0, 0, 1, 0, 0, 1, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'h03, 1, 8'h03, 0, 0, 1, 0, 0, 1, 16'h0101));
        vecs.push_back(mk(0, 8'h00, 8'h03, 1, 8'h03, 0, 0, 1, 0, 0, 1, 16'h0202));
        vecs.push_back(mk(0, 8'h00, 8'h03, 1, 8'h03, 0, 0, 1, 1, 0, 1, 16'h0303));
        vecs.push_back(mk(0, 8'h00, 8'h03, 1, 8'h03, 0, 0, 1, 1, 0, 0, 16'h0303));
        vecs.push_back(mk(0, 8'h00, 8'h03, 0, 8'h03, 0, 0, 1, 1, 0, 0, 16'h0303));

        rst_n = 1'b0;
        repeat (2) step();
        check("reset_state", outs(), 64'({8'h00, 6'b000100, 16'h0000}));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; start_addr = vecs[i].sa; end_addr = vecs[i].ea;
            rd_en = vecs[i].rd_en;
            step();
            check($sformatf("vec%0d", i), outs(),
                  64'({vecs[i].pc, vecs[i].en, vecs[i].bsy, vecs[i].dn, vecs[i].emp,
                       vecs[i].ful, vecs[i].rv, vecs[i].rd}));
        end
        start = 1'b0; rd_en = 1'b0;

        // Sweep 0..9 with no reads: fills at 8, stalls at PC 8, one pop releases one capture.
        start = 1'b1; start_addr = 8'h00; end_addr = 8'h09;
        step();
        start = 1'b0;
        cyc = 0;
        while (!full && cyc < 60) begin
            step();
            cyc++;
        end
        check("fill_full", 64'(full), 64'(1));
        repeat (6) step();
        check("stall_at_8", 64'({pc_n, enable, busy, done, full}), 64'({8'h08, 4'b1101}));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pop_push_full", 64'({full, rd_valid, rd_data}), 64'({2'b11, 16'h0000}));
        repeat (6) step();
        check("stall_at_9", 64'({pc_n, enable, busy, done, full}), 64'({8'h09, 4'b1101}));
        rd_en = 1'b1;
        k = 1; cyc = 0;
        while (k < 10 && cyc < 60) begin
            step();
            cyc++;
            if (rd_valid) begin
                check($sformatf("drain_%0d", k), 64'(rd_data), 64'(k * 16'h0101));
                k++;
            end
        end
        rd_en = 1'b0;
        check("drain_count", 64'(k), 64'(10));
        check("drain_done", 64'({done, busy, empty, full}), 64'(4'b1010));

        // Redirect: Load 7 during the WAIT of address 5 skips address 6.
        sweep("load", 8'h05, 8'h07, 1'b0, 1'b1, 8'h07, 2, 32'h0000_0507);
        drain("load", 2, {16'h0505, 16'h0707, 32'h0});

        // Wrap-around through 0.
        sweep("wrap", 8'hFE, 8'h01, 1'b0, 1'b0, 8'h00, 4, 32'hFEFF_0001);
        drain("wrap", 4, {16'hFEFE, 16'hFFFF, 16'h0000, 16'h0101});

        // Reset during the WAIT of address 2 with two entries captured.
        start = 1'b1; start_addr = 8'h00; end_addr = 8'h05;
        step();
        start = 1'b0;
        cyc = 0;
        while (pc_n != 8'h02 && cyc < 30) begin
            step();
            cyc++;
        end
        check("reach_pc2", 64'({pc_n, enable, busy, empty}), 64'({8'h02, 3'b110}));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_reset", outs(), 64'({8'h00, 6'b000100, 16'h0000}));

        // A Start while busy must not disturb the latched 3..4 range.
        sweep("busy_start", 8'h03, 8'h04, 1'b1, 1'b0, 8'h10, 2, 32'h0000_0304);
        drain("busy_start", 2, {16'h0303, 16'h0404, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
